// File: rtl/warp_issue_scheduler_if.sv
// Issue-unit handshake bundle: kernel launch, per-warp issue/exit
// requests and grants, and the liveness/status outputs of the IU.
interface warp_issue_scheduler_if #(
    parameter int NUM_WARPS = 8,
    parameter int WID_W     = 3
);
    logic                 Start_IU;
    logic [WID_W:0]       NumWarps_IU;
    logic [NUM_WARPS-1:0] Req_IB_IU;
    logic [NUM_WARPS-1:0] Exit_Req_IB_IU;
    logic                 Stall_IU;
    logic [NUM_WARPS-1:0] Grt_IU_IB;
    logic [NUM_WARPS-1:0] Exit_Grt_IU_IB;
    logic                 Issue_Valid_IU_OC;
    logic [WID_W-1:0]     Issue_WarpID_IU_OC;
    logic [NUM_WARPS-1:0] Alive_IU;
    logic                 Busy_IU;
    logic                 Done_IU;
    logic [31:0]          IssueCnt_IU;

    // Front end (instruction buffers / launch control) side
    modport master (
        output Start_IU, NumWarps_IU, Req_IB_IU, Exit_Req_IB_IU, Stall_IU,
        input  Grt_IU_IB, Exit_Grt_IU_IB, Issue_Valid_IU_OC, Issue_WarpID_IU_OC,
        input  Alive_IU, Busy_IU, Done_IU, IssueCnt_IU
    );

    // Issue unit side
    modport slave (
        input  Start_IU, NumWarps_IU, Req_IB_IU, Exit_Req_IB_IU, Stall_IU,
        output Grt_IU_IB, Exit_Grt_IU_IB, Issue_Valid_IU_OC, Issue_WarpID_IU_OC,
        output Alive_IU, Busy_IU, Done_IU, IssueCnt_IU
    );
endinterface

// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: zero-latency issue arbitration (loose round-robin,
// optionally greedy), fixed-priority exit arbitration, and warp liveness
// tracking from kernel launch to the kernel-done pulse.
module warp_issue_scheduler #(
    parameter int NUM_WARPS = 8,
    parameter int WID_W     = 3,
    parameter int GREEDY    = 0
) (
    input logic                    clk,
    input logic                    rst,
    warp_issue_scheduler_if.slave  iu
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [NUM_WARPS-1:0] alive_q, alive_d;
    logic [WID_W-1:0]     ptr_q, ptr_d;
    logic [WID_W-1:0]     last_q, last_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 gate;
    logic [NUM_WARPS-1:0] xelig, xgrt, elig, grt;
    logic [NUM_WARPS-1:0] launch_mask;
    logic [WID_W:0]       n_launch;
    logic [WID_W-1:0]     win, idx;
    logic                 found;

    // Issue counter increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Eligibility and exit grant; the exit winner is masked out of issue
    always_comb begin
        gate  = (state_q == S_RUN) && !iu.Stall_IU;
        xelig = iu.Exit_Req_IB_IU & alive_q & {NUM_WARPS{gate}};
        xgrt  = xelig & (~xelig + NUM_WARPS'(1));
        elig  = iu.Req_IB_IU & alive_q & {NUM_WARPS{gate}} & ~xgrt;
    end

    // Issue arbiter: greedy hold on the last warp, else first eligible from ptr
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = '0;
        if (GREEDY != 0 && elig[last_q]) begin
            found = 1'b1;
            win   = last_q;
        end
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = ptr_q + WID_W'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        grt = found ? (NUM_WARPS'(1) << win) : '0;
    end

    // Launch mask: out-of-range warp counts (0 or too many) mean all warps
    always_comb begin
        n_launch = (iu.NumWarps_IU == '0 || iu.NumWarps_IU > (WID_W+1)'(NUM_WARPS))
                   ? (WID_W+1)'(NUM_WARPS) : iu.NumWarps_IU;
        launch_mask = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            launch_mask[i] = ((WID_W+1)'(i) < n_launch);
        end
    end

    // Next state: FSM, liveness, arbitration pointers and issue counter
    always_comb begin
        state_d = state_q;
        alive_d = alive_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (found) begin
            ptr_d  = win + WID_W'(1);
            last_d = win;
            cnt_d  = sat_inc(cnt_q);
        end
        case (state_q)
            S_IDLE: begin
                if (iu.Start_IU) begin
                    state_d = S_RUN;
                    alive_d = launch_mask;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                alive_d = alive_q & ~xgrt;
                if ((|xgrt) && (alive_d == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State registers; reset drops straight back to IDLE with nothing live
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            alive_q <= '0;
            ptr_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= alive_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign iu.Grt_IU_IB          = grt;
    assign iu.Exit_Grt_IU_IB     = xgrt;
    assign iu.Issue_Valid_IU_OC  = found;
    assign iu.Issue_WarpID_IU_OC = found ? win : '0;
    assign iu.Alive_IU           = alive_q;
    assign iu.Busy_IU            = busy_q;
    assign iu.Done_IU            = done_q;
    assign iu.IssueCnt_IU        = cnt_q;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Testbench for warp_issue_scheduler: one LRR and one greedy instance,
// directed stimulus with expected grants queued at drive time and
// compared on the falling edge.
module tb_warp_issue_scheduler;

    logic clk;
    logic rst;

    warp_issue_scheduler_if #(.NUM_WARPS(8), .WID_W(3)) i_lrr ();
    warp_issue_scheduler_if #(.NUM_WARPS(8), .WID_W(3)) i_grd ();

    warp_issue_scheduler #(.NUM_WARPS(8), .WID_W(3), .GREEDY(0)) u_lrr (
        .clk (clk),
        .rst (rst),
        .iu  (i_lrr.slave)
    );

    warp_issue_scheduler #(.NUM_WARPS(8), .WID_W(3), .GREEDY(1)) u_grd (
        .clk (clk),
        .rst (rst),
        .iu  (i_grd.slave)
    );

    typedef struct {
        bit         sel;
        string      tag;
        logic [7:0] grt;
        logic [7:0] xgrt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int enc(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic drive(input bit sel, input logic [7:0] req, input logic [7:0] xreq, input logic stall);
        if (sel) begin
            i_grd.Req_IB_IU      = req;
            i_grd.Exit_Req_IB_IU = xreq;
            i_grd.Stall_IU       = stall;
        end else begin
            i_lrr.Req_IB_IU      = req;
            i_lrr.Exit_Req_IB_IU = xreq;
            i_lrr.Stall_IU       = stall;
        end
    endtask

    task automatic set_start(input bit sel, input logic s, input logic [3:0] n);
        if (sel) begin
            i_grd.Start_IU    = s;
            i_grd.NumWarps_IU = n;
        end else begin
            i_lrr.Start_IU    = s;
            i_lrr.NumWarps_IU = n;
        end
    endtask

    // One cycle of stimulus; the expected grants go onto the scoreboard
    task automatic step(input bit sel, input string tag, input logic [7:0] req,
                        input logic [7:0] xreq, input logic stall,
                        input logic [7:0] egrt, input logic [7:0] exgrt);
        exp_t e;
        @(posedge clk); #1;
        drive(sel, req, xreq, stall);
        e.sel  = sel;
        e.tag  = tag;
        e.grt  = egrt;
        e.xgrt = exgrt;
        sb.push_back(e);
    endtask

    task automatic launch(input bit sel, input logic [3:0] n);
        @(posedge clk); #1;
        drive(sel, 8'h00, 8'h00, 1'b0);
        set_start(sel, 1'b1, n);
        @(posedge clk); #1;
        set_start(sel, 1'b0, 4'd0);
    endtask

    // Scoreboard consumer: compare this cycle's grants on the falling edge
    exp_t       m;
    logic [7:0] mg, mxg;
    logic       mv;
    logic [2:0] mid;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m = sb.pop_front();
            if (m.sel) begin
                mg = i_grd.Grt_IU_IB; mxg = i_grd.Exit_Grt_IU_IB;
                mv = i_grd.Issue_Valid_IU_OC; mid = i_grd.Issue_WarpID_IU_OC;
            end else begin
                mg = i_lrr.Grt_IU_IB; mxg = i_lrr.Exit_Grt_IU_IB;
                mv = i_lrr.Issue_Valid_IU_OC; mid = i_lrr.Issue_WarpID_IU_OC;
            end
            check_eq({m.tag, ".grt"},  32'(mg),  32'(m.grt));
            check_eq({m.tag, ".xgrt"}, 32'(mxg), 32'(m.xgrt));
            check_eq({m.tag, ".vld"},  32'(mv),  32'(|m.grt));
            check_eq({m.tag, ".wid"},  32'(mid), 32'(enc(m.grt)));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        set_start(1'b0, 1'b0, 4'd0);
        set_start(1'b1, 1'b0, 4'd0);
        drive(1'b0, 8'hFF, 8'hFF, 1'b0);
        drive(1'b1, 8'hFF, 8'hFF, 1'b0);
        #3;
        check_eq("rst.grt",   32'(i_lrr.Grt_IU_IB), 32'h0);
        check_eq("rst.xgrt",  32'(i_lrr.Exit_Grt_IU_IB), 32'h0);
        check_eq("rst.vld",   32'(i_lrr.Issue_Valid_IU_OC), 32'h0);
        check_eq("rst.wid",   32'(i_lrr.Issue_WarpID_IU_OC), 32'h0);
        check_eq("rst.alive", 32'(i_lrr.Alive_IU), 32'h0);
        check_eq("rst.busy",  32'(i_lrr.Busy_IU), 32'h0);
        check_eq("rst.done",  32'(i_lrr.Done_IU), 32'h0);
        check_eq("rst.cnt",   i_lrr.IssueCnt_IU, 32'h0);
        check_eq("rst.g_grt", 32'(i_grd.Grt_IU_IB), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 8'h00, 8'h00, 1'b0);

        // Requests in IDLE are never granted
        step(0, "idle_req", 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00);

        // Launch 4 warps, round-robin over 0..3
        launch(0, 4'd4);
        @(negedge clk);
        check_eq("l4.alive", 32'(i_lrr.Alive_IU), 32'h0F);
        check_eq("l4.busy",  32'(i_lrr.Busy_IU), 32'h1);
        for (int k = 0; k < 8; k++) begin
            step(0, $sformatf("rr%0d", k), 8'h0F, 8'h00, 1'b0, 8'(1 << (k % 4)), 8'h00);
        end
        // Dead warps must not be granted
        step(0, "dead", 8'hF0, 8'h00, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check_eq("rr.cnt", i_lrr.IssueCnt_IU, 32'd8);

        // Exit and issue in the same cycle (ptr is 4 here)
        step(0, "ex0", 8'h02, 8'h03, 1'b0, 8'h02, 8'h01);
        step(0, "ex1", 8'h02, 8'h03, 1'b0, 8'h00, 8'h02);
        step(0, "ex2", 8'h08, 8'h04, 1'b0, 8'h08, 8'h04);
        check_eq("ex.alive", 32'(i_lrr.Alive_IU), 32'h0C);
        step(0, "ex3", 8'h00, 8'h08, 1'b0, 8'h00, 8'h08);

        // DONE cycle: start ignored, single pulse, back to IDLE
        @(posedge clk); #1;
        drive(0, 8'h00, 8'h00, 1'b0);
        set_start(0, 1'b1, 4'd8);
        @(negedge clk);
        check_eq("done.pulse", 32'(i_lrr.Done_IU), 32'h1);
        check_eq("done.busy",  32'(i_lrr.Busy_IU), 32'h0);
        check_eq("done.alive", 32'(i_lrr.Alive_IU), 32'h0);
        @(posedge clk); #1;
        set_start(0, 1'b0, 4'd0);
        @(negedge clk);
        check_eq("idle.done", 32'(i_lrr.Done_IU), 32'h0);
        check_eq("idle.busy", 32'(i_lrr.Busy_IU), 32'h0);

        // Relaunch with 0 warps (clamps to all); a Start in RUN is ignored
        launch(0, 4'd0);
        @(negedge clk);
        check_eq("l0.alive", 32'(i_lrr.Alive_IU), 32'hFF);
        check_eq("l0.cnt",   i_lrr.IssueCnt_IU, 32'h0);
        @(posedge clk); #1;
        set_start(0, 1'b1, 4'd2);
        @(posedge clk); #1;
        set_start(0, 1'b0, 4'd0);
        @(negedge clk);
        check_eq("srun.alive", 32'(i_lrr.Alive_IU), 32'hFF);
        check_eq("srun.busy",  32'(i_lrr.Busy_IU), 32'h1);

        // Wrap-around from 7 to 0, then stall holds ptr and counter
        step(0, "w6",    8'h40, 8'h00, 1'b0, 8'h40, 8'h00);
        step(0, "w7",    8'h81, 8'h00, 1'b0, 8'h80, 8'h00);
        step(0, "w0",    8'h81, 8'h00, 1'b0, 8'h01, 8'h00);
        step(0, "stall", 8'h81, 8'h01, 1'b1, 8'h00, 8'h00);
        step(0, "w7b",   8'h81, 8'h00, 1'b0, 8'h80, 8'h00);
        step(0, "quiet", 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        check_eq("wrap.cnt", i_lrr.IssueCnt_IU, 32'd4);

        // Reset in the middle of a run with all warps requesting
        step(0, "pre_rst", 8'hFF, 8'h00, 1'b0, 8'h01, 8'h00);
        @(posedge clk); #1;
        #1 rst = 1'b0;
        #1;
        check_eq("mrst.grt",   32'(i_lrr.Grt_IU_IB), 32'h0);
        check_eq("mrst.vld",   32'(i_lrr.Issue_Valid_IU_OC), 32'h0);
        check_eq("mrst.alive", 32'(i_lrr.Alive_IU), 32'h0);
        check_eq("mrst.busy",  32'(i_lrr.Busy_IU), 32'h0);
        check_eq("mrst.cnt",   i_lrr.IssueCnt_IU, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("mrst.done%0d", k), 32'(i_lrr.Done_IU), 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 8'h00, 8'h00, 1'b0);

        // Greedy instance: stays on warp 1, moves on when it drops, then stays on 2
        launch(1, 4'd8);
        step(1, "g0", 8'h06, 8'h00, 1'b0, 8'h02, 8'h00);
        step(1, "g1", 8'h06, 8'h00, 1'b0, 8'h02, 8'h00);
        step(1, "g2", 8'h06, 8'h00, 1'b0, 8'h02, 8'h00);
        step(1, "g3", 8'h04, 8'h00, 1'b0, 8'h04, 8'h00);
        step(1, "g4", 8'h06, 8'h00, 1'b0, 8'h04, 8'h00);
        step(1, "g5", 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        check_eq("g.cnt", i_grd.IssueCnt_IU, 32'd5);

        @(negedge clk); #1;
        check_eq("sb.empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
